mem_responder: RTL



---
 rtl/mem_responder_pkg.sv | 18 +
 rtl/mem_lane_align.sv | 63 ++++++
 rtl/mem_responder.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
// Shared constants and types for the CPU memory-side responder.
package mem_responder_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  localparam logic MEM_NOT_BUSY = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores, load extract/extend and access fault decode.
module mem_lane_align
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic        rd_i,
  input  logic        wr_i,
  input  logic [31:0] wd_i,
  input  logic [31:0] ram_word_i,
  output logic [3:0]  be_c,
  output logic [31:0] wdata_c,
  output logic [31:0] ld_data_c,
  output logic        fault_c
);

  logic [1:0]  lane;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        misalign;
  logic        illegal;
  logic        out_of_range;

  assign lane = addr_i[1:0];

  always_comb begin
    be_c      = '0;
    wdata_c   = wd_i;
    ld_data_c = ram_word_i;
    misalign  = 1'b0;
    illegal   = 1'b0;
    ld_byte   = ram_word_i[{lane, 3'b000} +: 8];
    ld_half   = lane[1] ? ram_word_i[31:16] : ram_word_i[15:0];

    case (funct3_i)
      MEM_B, MEM_BU: begin
        be_c      = 4'b0001 << lane;
        wdata_c   = {4{wd_i[7:0]}};
        ld_data_c = funct3_i[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      end
      MEM_H, MEM_HU: begin
        be_c      = lane[1] ? 4'b1100 : 4'b0011;
        wdata_c   = {2{wd_i[15:0]}};
        ld_data_c = funct3_i[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
        misalign  = lane[0];
      end
      MEM_W: begin
        be_c     = 4'b1111;
        misalign = (lane != 2'b00);
      end
      default: illegal = 1'b1;
    endcase

    // Unsigned sizes have no meaning for stores
    if (wr_i && funct3_i[2]) illegal = 1'b1;

    out_of_range = ((addr_i >> (ADDR_WIDTH + 2)) != 32'd0);
    fault_c      = misalign | illegal | out_of_range | (rd_i & wr_i);
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: request FSM with programmable wait states over a word-wide RAM.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  mrd_i,
  input  logic                  mwr_i,
  input  logic [2:0]            funct3_i,
  input  logic [31:0]           byte_addr_i,
  input  logic [DATA_WIDTH-1:0] wd_i,
  output logic [DATA_WIDTH-1:0] rd_o,
  output logic                  mem_busy_o,
  output logic                  mem_rdy_o,
  output logic                  fault_o
);

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned WS_INIT   = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [31:0]             addr_q, addr_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [DATA_WIDTH-1:0]   wd_q, wd_d;
  logic                    rd_req_q, rd_req_d;
  logic                    wr_req_q, wr_req_d;
  logic [DATA_WIDTH-1:0]   rd_q, rd_d;
  logic                    busy_q, busy_d;
  logic                    rdy_q, rdy_d;
  logic                    fault_q, fault_d;

  logic [DATA_WIDTH-1:0]   ram [RAM_DEPTH];

  logic                    in_idle_c;
  logic [31:0]             req_addr_c;
  logic [2:0]              req_funct3_c;
  logic [DATA_WIDTH-1:0]   req_wd_c;
  logic                    req_rd_c;
  logic                    req_wr_c;
  logic [ADDR_WIDTH-1:0]   req_idx_c;
  logic [DATA_WIDTH-1:0]   ram_word_c;
  logic [3:0]              be_c;
  logic [31:0]             wdata_c;
  logic [31:0]             ld_data_c;
  logic                    fault_c;
  logic                    ram_we_c;

  // With zero wait states the access happens on the accept edge, so use live inputs in IDLE
  assign in_idle_c    = (state_q == ST_IDLE);
  assign req_addr_c   = in_idle_c ? byte_addr_i : addr_q;
  assign req_funct3_c = in_idle_c ? funct3_i    : funct3_q;
  assign req_wd_c     = in_idle_c ? wd_i        : wd_q;
  assign req_rd_c     = in_idle_c ? mrd_i       : rd_req_q;
  assign req_wr_c     = in_idle_c ? mwr_i       : wr_req_q;
  assign req_idx_c    = req_addr_c[ADDR_WIDTH+1:2];
  assign ram_word_c   = ram[req_idx_c];

  mem_lane_align #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_align (
    .funct3_i   (req_funct3_c),
    .addr_i     (req_addr_c),
    .rd_i       (req_rd_c),
    .wr_i       (req_wr_c),
    .wd_i       (req_wd_c),
    .ram_word_i (ram_word_c),
    .be_c       (be_c),
    .wdata_c    (wdata_c),
    .ld_data_c  (ld_data_c),
    .fault_c    (fault_c)
  );

  // Next-state and output decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    wd_d     = wd_q;
    rd_req_d = rd_req_q;
    wr_req_d = wr_req_q;
    rd_d     = rd_q;
    fault_d  = fault_q;

    case (state_q)
      ST_IDLE: begin
        if (mrd_i || mwr_i) begin
          addr_d   = byte_addr_i;
          funct3_d = funct3_i;
          wd_d     = wd_i;
          rd_req_d = mrd_i;
          wr_req_d = mwr_i;
          fault_d  = 1'b0;
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WS_INIT);
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_DONE) begin
      fault_d = fault_c;
      if (req_rd_c && !req_wr_c) rd_d = fault_c ? '0 : ld_data_c;
    end

    busy_d = (state_d == ST_WAIT) ? ~MEM_NOT_BUSY : MEM_NOT_BUSY;
    rdy_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      funct3_q <= '0;
      wd_q     <= '0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      rd_q     <= '0;
      busy_q   <= MEM_NOT_BUSY;
      rdy_q    <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      wd_q     <= wd_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
      rdy_q    <= rdy_d;
      fault_q  <= fault_d;
    end
  end

  // RAM write on the edge entering DONE; contents survive reset
  assign ram_we_c = (state_d == ST_DONE) && req_wr_c && !fault_c && !reset_i;

  always_ff @(posedge clk_i) begin
    if (ram_we_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) ram[req_idx_c][8*i +: 8] <= wdata_c[8*i +: 8];
      end
    end
  end

  assign rd_o       = rd_q;
  assign mem_busy_o = busy_q;
  assign mem_rdy_o  = rdy_q;
  assign fault_o    = fault_q;

endmodule
